// File: rtl/alu_writeback.sv
// alu_writeback: ALU result writeback with a 2-entry retire FIFO, load port,
// 16x16 register file and flags register. Define WB_BYPASS_EN to forward reads.
module alu_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_we,
  input  logic [3:0]  in_dst_reg,
  input  logic [15:0] in_data,
  input  logic        in_flags_we,
  input  logic [3:0]  in_flags,
  input  logic        mem_we,
  input  logic [3:0]  mem_reg,
  input  logic [15:0] mem_data,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b,
  output logic [3:0]  flags,
  output logic [1:0]  pending
);

  typedef struct packed {
    logic        reg_we;
    logic [3:0]  dst;
    logic [15:0] data;
    logic        flags_we;
    logic [3:0]  flags;
  } wb_ent_t;

  // Slot 0 is always the head; slot 1 holds the younger entry when full.
  wb_ent_t     r_q [2];
  logic [1:0]  r_cnt;
  logic [15:0] r_rf [16];
  logic [3:0]  r_flags;

  wb_ent_t     w_in_ent;
  wb_ent_t     w_head;
  logic        w_push;
  logic        w_pop;
  logic        w_wr_hi;
  logic [1:0]  w_cnt_nxt;

  assign in_ready = (r_cnt != 2'd2);
  assign pending  = r_cnt;
  assign flags    = r_flags;

  assign w_in_ent = '{
    reg_we:   in_reg_we,
    dst:      in_dst_reg,
    data:     in_data,
    flags_we: in_flags_we,
    flags:    in_flags
  };

  assign w_head = r_q[0];
  assign w_push = in_valid & in_ready;
  // The load port owns the write path, so a load stalls retirement.
  assign w_pop  = ~mem_we & (r_cnt != 2'd0);
  // Push lands behind whatever survives this cycle's retire.
  assign w_wr_hi = (r_cnt == 2'd1) & ~w_pop;
  assign w_cnt_nxt = r_cnt
                   + {1'b0, w_push}
                   - {1'b0, w_pop};

  // FIFO storage and occupancy: shift on retire, then place the push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 2'd0;
      r_q[0] <= '0;
      r_q[1] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_pop) begin
        r_q[0] <= r_q[1];
      end
      if (w_push) begin
        if (w_wr_hi) begin
          r_q[1] <= w_in_ent;
        end else begin
          r_q[0] <= w_in_ent;
        end
      end
    end
  end

  // Register file: load write wins, otherwise the retiring head writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_rf[i] <= 16'h0000;
      end
    end else if (mem_we) begin
      r_rf[mem_reg] <= mem_data;
    end else if (w_pop && w_head.reg_we) begin
      r_rf[w_head.dst] <= w_head.data;
    end
  end

  // Flags register: only a retiring entry with flags_we updates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_pop && w_head.flags_we) begin
      r_flags <= w_head.flags;
    end
  end

`ifdef WB_BYPASS_EN
  logic w_mem_fwd;

  // Load data is not yet committed while reset holds the block idle.
  assign w_mem_fwd = mem_we & ~reset;

  function automatic logic [15:0] f_fwd(
    input logic [3:0]  addr,
    input wb_ent_t     q0,
    input wb_ent_t     q1,
    input logic [1:0]  cnt,
    input logic        ld_we,
    input logic [3:0]  ld_reg,
    input logic [15:0] ld_data,
    input logic [15:0] rf_val
  );
    logic [15:0] v;
    v = rf_val;
    if (ld_we && (ld_reg == addr)) begin
      v = ld_data;
    end
    if ((cnt != 2'd0) && q0.reg_we && (q0.dst == addr)) begin
      v = q0.data;
    end
    if ((cnt == 2'd2) && q1.reg_we && (q1.dst == addr)) begin
      v = q1.data;
    end
    return v;
  endfunction

  // Read port A: youngest queued match, older match, load, then RF.
  always_comb begin
    rd_data_a = f_fwd(rd_addr_a, r_q[0], r_q[1], r_cnt,
                      w_mem_fwd, mem_reg, mem_data,
                      r_rf[rd_addr_a]);
  end

  // Read port B: same forwarding priority as port A.
  always_comb begin
    rd_data_b = f_fwd(rd_addr_b, r_q[0], r_q[1], r_cnt,
                      w_mem_fwd, mem_reg, mem_data,
                      r_rf[rd_addr_b]);
  end
`else
  // Read port A: committed register state only.
  always_comb begin
    rd_data_a = r_rf[rd_addr_a];
  end

  // Read port B: committed register state only.
  always_comb begin
    rd_data_b = r_rf[rd_addr_b];
  end
`endif

endmodule
